// File: rtl/xlu_seq_ctrl.sv
// rtl/xlu_seq_ctrl.sv - HI/LO multiply/divide sequencer; define XLU_MADD_EN to enable madd/maddu/msub/msubu.
module xlu_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  xlu_op,
    input  logic        e_valid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        d_is_xlu,
    output logic        start,
    output logic        busy,
    output logic        stall_xlu,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] xlu_out
);

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MTHI  = 4'b0100;
    localparam logic [3:0] OP_MTLO  = 4'b0101;
    localparam logic [3:0] OP_MFHI  = 4'b0110;
    localparam logic [3:0] OP_MFLO  = 4'b0111;
`ifdef XLU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b1001;
    localparam logic [3:0] OP_MADDU = 4'b1010;
    localparam logic [3:0] OP_MSUB  = 4'b1011;
    localparam logic [3:0] OP_MSUBU = 4'b1100;
`endif

    localparam logic [3:0] MUL_CNT = 4'd4;
    localparam logic [3:0] DIV_CNT = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        op_is_mul;
    logic        op_is_div;

    always_comb begin
        op_is_mul = (xlu_op == OP_MULT) || (xlu_op == OP_MULTU);
`ifdef XLU_MADD_EN
        op_is_mul = op_is_mul || (xlu_op == OP_MADD) || (xlu_op == OP_MADDU) ||
                    (xlu_op == OP_MSUB) || (xlu_op == OP_MSUBU);
`endif
        op_is_div = (xlu_op == OP_DIV) || (xlu_op == OP_DIVU);
    end

    // Gated by reset so nothing is reported as issued while the block is held in reset.
    assign start     = reset && e_valid && (state_q == IDLE) && (op_is_mul || op_is_div);
    assign busy      = (state_q != IDLE);
    assign stall_xlu = d_is_xlu && (start || busy);
    assign HI        = hi_q;
    assign LO        = lo_q;

    always_comb begin
        case (xlu_op)
            OP_MFHI: xlu_out = hi_q;
            OP_MFLO: xlu_out = lo_q;
            default: xlu_out = 32'd0;
        endcase
    end

    logic [63:0]        hilo;
    logic [63:0]        a_sx, b_sx;
    logic [63:0]        prod_s, prod_u;
    logic signed [31:0] quot_s, rem_s;
    logic [31:0]        quot_u, rem_u;
    logic [63:0]        mul_res, div_res;

    assign hilo   = {hi_q, lo_q};
    assign a_sx   = {{32{a_q[31]}}, a_q};
    assign b_sx   = {{32{b_q[31]}}, b_q};
    // Sign-extended operands give the signed product modulo 2^64.
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    assign quot_s = $signed(a_q) / $signed(b_q);
    assign rem_s  = $signed(a_q) % $signed(b_q);
    assign quot_u = a_q / b_q;
    assign rem_u  = a_q % b_q;

    always_comb begin
        case (op_q)
            OP_MULT:  mul_res = prod_s;
            OP_MULTU: mul_res = prod_u;
`ifdef XLU_MADD_EN
            OP_MADD:  mul_res = hilo + prod_s;
            OP_MADDU: mul_res = hilo + prod_u;
            OP_MSUB:  mul_res = hilo - prod_s;
            OP_MSUBU: mul_res = hilo - prod_u;
`endif
            default:  mul_res = hilo;
        endcase
    end

    // A zero divisor still runs the full latency but leaves HI/LO untouched.
    always_comb begin
        if (b_q == 32'd0) begin
            div_res = hilo;
        end else if (op_q == OP_DIV) begin
            div_res = {rem_s, quot_s};
        end else begin
            div_res = {rem_u, quot_u};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = xlu_op;
                    state_d = op_is_div ? DIV : MUL;
                    cnt_d   = op_is_div ? DIV_CNT : MUL_CNT;
                end else if (e_valid && (xlu_op == OP_MTHI)) begin
                    hi_d = A;
                end else if (e_valid && (xlu_op == OP_MTLO)) begin
                    lo_d = A;
                end
            end
            MUL, DIV: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    if (state_q == DIV) begin
                        {hi_d, lo_d} = div_res;
                    end else begin
                        {hi_d, lo_d} = mul_res;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_xlu_seq_ctrl.sv
// tb/tb_xlu_seq_ctrl.sv - Randomized self-checking bench for xlu_seq_ctrl against an arithmetic HI/LO model.
module tb_xlu_seq_ctrl;

`ifdef XLU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;
    localparam logic [3:0] OP_NONE  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  xlu_op;
    logic        e_valid;
    logic [31:0] A, B;
    logic        d_is_xlu;
    logic        start, busy, stall_xlu;
    logic [31:0] HI, LO, xlu_out;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi, m_lo;

    xlu_seq_ctrl dut (
        .clk(clk), .reset(reset), .xlu_op(xlu_op), .e_valid(e_valid),
        .A(A), .B(B), .d_is_xlu(d_is_xlu), .start(start), .busy(busy),
        .stall_xlu(stall_xlu), .HI(HI), .LO(LO), .xlu_out(xlu_out)
    );

    always #5 clk = ~clk;

    function automatic bit model_starts(input logic [3:0] op);
        if (op <= OP_DIVU) return 1'b1;
        if (MADD_EN && op >= 4'd9 && op <= 4'd12) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_latency(input logic [3:0] op);
        if (op == OP_DIV || op == OP_DIVU) return 10;
        return 5;
    endfunction

    function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] hilo);
        logic [63:0] ps, pu;
        int sa, sb;
        ps = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        pu = {32'd0, a} * {32'd0, b};
        sa = a;
        sb = b;
        case (op)
            4'd0: return ps;
            4'd1: return pu;
            4'd2: return (b == 0) ? hilo : {32'(sa % sb), 32'(sa / sb)};
            4'd3: return (b == 0) ? hilo : {a % b, a / b};
            4'd9: return hilo + ps;
            4'd10: return hilo + pu;
            4'd11: return hilo - ps;
            4'd12: return hilo - pu;
            default: return hilo;
        endcase
    endfunction

    // Issues one op in the current cycle and follows it to completion; returns in the first idle cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit          exp_start;
        int          exp_len, n, stalls, exp_stalls;
        logic [63:0] exp_hilo;
        xlu_op = op; e_valid = 1'b1; A = a; B = b;
        #1;
        exp_start = model_starts(op);
        exp_len   = exp_start ? model_latency(op) : 0;
        exp_hilo  = model_result(op, a, b, {m_hi, m_lo});
        checks++;
        if (start !== exp_start) begin
            failures++;
            $display("FAIL start op=%0d got=%b exp=%b", op, start, exp_start);
        end
        stalls = stall_xlu ? 1 : 0;
        @(posedge clk); #1;
        xlu_op = OP_NONE; e_valid = 1'b0;
        if (op == OP_MTHI) m_hi = a;
        if (op == OP_MTLO) m_lo = a;
        if (exp_start) begin
            n = 0;
            while (busy === 1'b1 && n < 20) begin
                checks++;
                if (HI !== m_hi || LO !== m_lo) begin
                    failures++;
                    $display("FAIL hold_while_busy got=%h_%h exp=%h_%h", HI, LO, m_hi, m_lo);
                end
                if (stall_xlu) stalls++;
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (n != exp_len) begin
                failures++;
                $display("FAIL busy_len op=%0d got=%0d exp=%0d", op, n, exp_len);
            end
            {m_hi, m_lo} = exp_hilo;
        end
        exp_stalls = (d_is_xlu && exp_start) ? exp_len + 1 : 0;
        checks++;
        if (stalls != exp_stalls || busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_count op=%0d got=%0d exp=%0d busy=%b", op, stalls, exp_stalls, busy);
        end
        checks++;
        if (HI !== m_hi || LO !== m_lo) begin
            failures++;
            $display("FAIL hilo op=%0d a=%h b=%h got=%h_%h exp=%h_%h", op, a, b, HI, LO, m_hi, m_lo);
        end
        xlu_op = OP_MFHI; #1;
        checks++;
        if (xlu_out !== m_hi) begin
            failures++;
            $display("FAIL mfhi got=%h exp=%h", xlu_out, m_hi);
        end
        xlu_op = OP_MFLO; #1;
        checks++;
        if (xlu_out !== m_lo) begin
            failures++;
            $display("FAIL mflo got=%h exp=%h", xlu_out, m_lo);
        end
        xlu_op = OP_NONE;
    endtask

    task automatic test_reset();
        reset = 1'b0; xlu_op = OP_MULT; e_valid = 1'b1; A = 32'h5; B = 32'h7; d_is_xlu = 1'b1;
        #1;
        checks++;
        if (start !== 1'b0 || busy !== 1'b0 || stall_xlu !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl start=%b busy=%b stall=%b exp=0", start, busy, stall_xlu);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_hilo got=%h_%h busy=%b exp=0", HI, LO, busy);
        end
        xlu_op = OP_NONE; e_valid = 1'b0; d_is_xlu = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL mult_vec got=%h_%h exp=ffffffff_fffffffe", HI, LO);
        end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        checks++;
        if (HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL multu_vec got=%h_%h exp=00000001_fffffffe", HI, LO);
        end
    endtask

    task automatic test_div();
        run_op(OP_DIV, -32'sd7, 32'd2);
        checks++;
        if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div_vec got=%h_%h exp=ffffffff_fffffffd", HI, LO);
        end
        run_op(OP_DIVU, 32'd7, 32'd0);
        checks++;
        if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL divu_zero got=%h_%h exp=ffffffff_fffffffd", HI, LO);
        end
    endtask

    task automatic test_stall();
        d_is_xlu = 1'b1;
        run_op(OP_MULT, 32'd1234, 32'd5678);
        run_op(OP_MTLO, 32'hCAFE_0001, 32'd0);
        d_is_xlu = 1'b0;
    endtask

    task automatic test_madd();
        logic [31:0] exp_hi;
        run_op(OP_MTHI, 32'h1234_5678, 32'd0);
        run_op(OP_MTLO, 32'd0, 32'd0);
        run_op(OP_MADD, 32'h0001_0000, 32'h0001_0000);
        exp_hi = MADD_EN ? 32'h1234_5679 : 32'h1234_5678;
        checks++;
        if (HI !== exp_hi || LO !== 32'd0) begin
            failures++;
            $display("FAIL madd_vec got=%h_%h exp=%h_00000000", HI, LO, exp_hi);
        end
    endtask

    task automatic test_reset_mid_div();
        run_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        run_op(OP_MTLO, 32'h0BAD_F00D, 32'd0);
        xlu_op = OP_DIV; e_valid = 1'b1; A = 32'd100; B = 32'd3;
        @(posedge clk); #1;
        xlu_op = OP_NONE; e_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("FAIL reset_abort busy=%b got=%h_%h exp=0", busy, HI, LO);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("FAIL reset_no_write busy=%b got=%h_%h exp=0", busy, HI, LO);
        end
    endtask

    task automatic test_back_to_back();
        run_op(OP_DIV, 32'd100, 32'd7);
        run_op(OP_MULTU, 32'h8000_0001, 32'h0000_0003);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20)) - 32'd10;
            if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            d_is_xlu = 1'($urandom_range(0, 1));
            run_op(op, a, b);
        end
        d_is_xlu = 1'b0;
    endtask

    initial begin
        m_hi = 32'd0; m_lo = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_madd();
        test_reset_mid_div();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xlu_seq_ctrl.md
XLU_SEQ_CTRL -- requirements
Module: xlu_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have port xlu_op, input, 4, E-stage op code: 0000 mult, 0001 multu, 0010 div, 0011 divu, 0100 mthi, 0101 mtlo, 0110 mfhi, 0111 mflo, 1000 none, 1001 madd, 1010 maddu, 1011 msub, 1100 msubu; other values = none.
REQ-004 SHALL have port e_valid, input, 1, E-stage instruction is real (not a bubble or flushed).
REQ-005 SHALL have ports A and B, input, 32 each, rs and rt operands from E-stage forwarding.
REQ-006 SHALL have port d_is_xlu, input, 1, D-stage instruction uses HI/LO (any xlu_op other than none).
REQ-007 SHALL have port start, output, 1, a multi-cycle op is issued this cycle.
REQ-008 SHALL have port busy, output, 1, a multi-cycle op is in progress.
REQ-009 SHALL have port stall_xlu, output, 1, D-stage stall request: d_is_xlu & (start | busy).
REQ-010 SHALL have ports HI and LO, output, 32 each, architectural HI/LO registers.
REQ-011 SHALL have port xlu_out, output, 32, HI when xlu_op=mfhi, LO when xlu_op=mflo, else 0; combinational.

Function
REQ-012 SHALL implement states IDLE, MUL and DIV, plus a 4-bit down-counter cnt.
REQ-013 start SHALL be combinational: e_valid & state==IDLE & xlu_op in {mult, multu, div, divu, madd, maddu, msub, msubu}.
REQ-014 On start with a multiply-class op (cycle T), SHALL latch A, B and the op; enter MUL with cnt=4; busy high in cycles T+1..T+5.
REQ-015 On start with div/divu, SHALL enter DIV with cnt=9; busy high in cycles T+1..T+10.
REQ-016 In MUL/DIV, SHALL decrement cnt each cycle; at the edge where cnt==0, SHALL write HI/LO and return to IDLE; busy low from the next cycle.
REQ-017 HI/LO results SHALL become visible only at completion; HI/LO hold their old values while busy.
REQ-018 mult SHALL write {HI,LO} = signed 64-bit product; multu SHALL write the unsigned 64-bit product.
REQ-019 div SHALL write LO=signed quotient (truncate toward zero) and HI=remainder (sign of dividend); divu SHALL use unsigned.
REQ-020 With divisor 0, div/divu SHALL still run the full 10 busy cycles and leave HI/LO unchanged.
REQ-021 madd/maddu SHALL write {HI,LO} = {HI,LO} + product; msub/msubu SHALL write {HI,LO} = {HI,LO} - product; modulo 2^64; the {HI,LO} read at completion is the operand.
REQ-022 mthi/mtlo with e_valid and state IDLE SHALL write A into HI/LO at the end of that cycle.
REQ-023 Any xlu_op other than none arriving with e_valid while busy SHALL be ignored, with no state change (upstream stall guarantees it never occurs).
REQ-024 A start in the cycle busy drops (IDLE again) SHALL be accepted normally (back-to-back issue, no gap cycle).
REQ-025 mfhi/mflo in the completion-plus-one cycle SHALL return the new HI/LO.
REQ-026 stall_xlu SHALL be asserted in the start cycle and all busy cycles whenever d_is_xlu=1.

Reset
REQ-027 reset=0 SHALL asynchronously force state=IDLE, cnt=0, HI=0, LO=0 and latched operands=0; busy=0 and start=0 while in reset.
REQ-028 Reset during MUL/DIV SHALL abort the op; no HI/LO write occurs after release.

Configuration
REQ-029 Macro XLU_MADD_EN defined: madd/maddu/msub/msubu SHALL behave per REQ-021.
REQ-030 Macro XLU_MADD_EN undefined: codes 1001-1100 SHALL be treated as none (no start, no HI/LO change, stall_xlu unaffected by them in E).

Verification
REQ-031 mult with A=0xFFFFFFFF, B=2 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 div with A=-7, B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with A=7, B=0 -> 10 busy cycles, HI/LO unchanged.
REQ-033 mult issued, d_is_xlu=1 throughout -> stall_xlu high for exactly 6 cycles (start plus 5 busy); mfhi in the following cycle returns the new HI.
REQ-034 mthi A=0x12345678, then madd with HI=0x12345678, LO=0, A=B=0x10000 -> HI=0x12345679, LO=0; with XLU_MADD_EN undefined -> no start, HI/LO unchanged.
REQ-035 reset pulsed low in busy cycle 3 of div -> busy=0 immediately, HI=LO=0, and no later write.
REQ-036 Back-to-back: multu issued in the first IDLE cycle after the prior div -> start=1 that cycle, result correct 5 cycles later.
